// File: rtl/memtest_stats_bcd.sv
// memtest_stats_bcd: periodic coherent snapshot of the tester pass/fail
// counters, converted to packed BCD by a bit-serial double-dabble engine and
// published together with a one-cycle update strobe.
//
// Ports:
//   clk            system clock, all state in this domain
//   rst            asynchronous active-high reset
//   passcount      binary pass counter (CNT_W)
//   failcount      binary fail counter (CNT_W)
//   force_update   level-sampled request for an immediate snapshot
//   pass_bcd       packed BCD of snapshot passcount, digit 0 in [3:0]
//   fail_bcd       packed BCD of snapshot failcount
//   upd            one-cycle pulse when pass_bcd/fail_bcd change
//   busy           conversion in progress
//   first_fail_bcd (MEMTEST_FIRSTFAIL_EN) BCD of passcount at first nonzero failcount
//   fail_seen      (MEMTEST_FIRSTFAIL_EN) sticky flag, first failing snapshot seen
//
// Optional feature macro: MEMTEST_FIRSTFAIL_EN adds the first-fail capture and
// a third conversion pass.
module memtest_stats_bcd #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIGITS      = 10,
  parameter int unsigned REFRESH_DIV = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      passcount,
  input  logic [CNT_W-1:0]      failcount,
  input  logic                  force_update,
  output logic [4*DIGITS-1:0]   pass_bcd,
  output logic [4*DIGITS-1:0]   fail_bcd,
  output logic                  upd,
  output logic                  busy
`ifdef MEMTEST_FIRSTFAIL_EN
  ,
  output logic [4*DIGITS-1:0]   first_fail_bcd,
  output logic                  fail_seen
`endif
);

  localparam int unsigned BCD_W      = 4 * DIGITS;
  localparam int unsigned RC_W       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BC_W       = $clog2(CNT_W + 1);
  // ceil(CNT_W * log10(2)) using a fixed-point approximation of log10(2)
  localparam int unsigned MIN_DIGITS = (CNT_W * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_bad_digits
    $error("memtest_stats_bcd: DIGITS too small for CNT_W");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("memtest_stats_bcd: REFRESH_DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_P  = 3'd1,
    SHIFT_F  = 3'd2,
    SHIFT_FF = 3'd3,
    PUBLISH  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [RC_W-1:0]   rcnt;
  logic              tick;
  logic              pending;
  logic              trigger;
  logic              accept;
  logic              shift_en;
  logic              phase_end;
  logic              publish;
  logic              last_bit;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  sh;
  logic [CNT_W-1:0]  fail_snap;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_next;
  logic [BCD_W-1:0]  pass_tmp;
`ifdef MEMTEST_FIRSTFAIL_EN
  logic [BCD_W-1:0]  fail_tmp;
  logic [CNT_W-1:0]  ff_val;
`endif

  // One double-dabble step: correct every digit >= 5, then shift in one bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] a,
                                                   input logic             b);
    logic [BCD_W-1:0] c;
    c = a;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c[4*i +: 4] >= 4'd5) c[4*i +: 4] = c[4*i +: 4] + 4'd3;
    end
    return {c[BCD_W-2:0], b};
  endfunction

  assign tick     = (rcnt == RC_W'(REFRESH_DIV - 1));
  assign trigger  = tick | force_update | pending;
  assign last_bit = (bit_cnt == BC_W'(CNT_W - 1));
  assign acc_next = dabble_step(acc, sh[CNT_W-1]);

  // Free-running refresh divider, never paused by a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rcnt <= '0;
    else     rcnt <= tick ? '0 : rcnt + RC_W'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    phase_end = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          accept  = 1'b1;
          state_n = SHIFT_P;
        end
      end
      SHIFT_P: begin
        shift_en = 1'b1;
        if (last_bit) begin
          phase_end = 1'b1;
          state_n   = SHIFT_F;
        end
      end
      SHIFT_F: begin
        shift_en = 1'b1;
        if (last_bit) begin
          phase_end = 1'b1;
`ifdef MEMTEST_FIRSTFAIL_EN
          state_n   = SHIFT_FF;
`else
          state_n   = PUBLISH;
`endif
        end
      end
      SHIFT_FF: begin
        shift_en = 1'b1;
        if (last_bit) begin
          phase_end = 1'b1;
          state_n   = PUBLISH;
        end
      end
      PUBLISH: begin
        publish = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Requests arriving while busy collapse into a single pending bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pending <= 1'b0;
    else if (state != IDLE) pending <= pending | tick | force_update;
    else                    pending <= 1'b0;
  end

  // Snapshot, conversion datapath and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh             <= '0;
      fail_snap      <= '0;
      acc            <= '0;
      bit_cnt        <= '0;
      pass_tmp       <= '0;
      pass_bcd       <= '0;
      fail_bcd       <= '0;
      upd            <= 1'b0;
      busy           <= 1'b0;
`ifdef MEMTEST_FIRSTFAIL_EN
      fail_tmp       <= '0;
      ff_val         <= '0;
      first_fail_bcd <= '0;
      fail_seen      <= 1'b0;
`endif
    end else begin
      upd  <= publish;
      busy <= (state_n != IDLE);
      if (accept) begin
        sh        <= passcount;
        fail_snap <= failcount;
        acc       <= '0;
        bit_cnt   <= '0;
`ifdef MEMTEST_FIRSTFAIL_EN
        if (!fail_seen && (failcount != '0)) begin
          fail_seen <= 1'b1;
          ff_val    <= passcount;
        end
`endif
      end else if (shift_en) begin
        acc     <= acc_next;
        sh      <= {sh[CNT_W-2:0], 1'b0};
        bit_cnt <= phase_end ? '0 : bit_cnt + BC_W'(1);
        if (phase_end && (state == SHIFT_P)) begin
          pass_tmp <= acc_next;
          acc      <= '0;
          sh       <= fail_snap;
        end
`ifdef MEMTEST_FIRSTFAIL_EN
        if (phase_end && (state == SHIFT_F)) begin
          fail_tmp <= acc_next;
          acc      <= '0;
          sh       <= ff_val;
        end
`endif
      end
      if (publish) begin
        pass_bcd       <= pass_tmp;
`ifdef MEMTEST_FIRSTFAIL_EN
        fail_bcd       <= fail_tmp;
        first_fail_bcd <= acc;
`else
        fail_bcd       <= acc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_memtest_stats_bcd.sv
// Testbench for memtest_stats_bcd: directed vector table for the conversion,
// plus hand-written sequences for coherency, pending chaining, refresh cadence,
// mid-conversion reset and the optional first-fail capture.
module tb_memtest_stats_bcd;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned BW    = 40;
`ifdef MEMTEST_FIRSTFAIL_EN
  localparam int LAT   = 97;
  localparam int CAD50 = 98;
`else
  localparam int LAT   = 65;
  localparam int CAD50 = 66;
`endif

  logic              clk;
  logic              rst;
  logic              rst2;
  logic [CNT_W-1:0]  passcount;
  logic [CNT_W-1:0]  failcount;
  logic              force_update;
  logic [BW-1:0]     pass_bcd, fail_bcd;
  logic              upd, busy;
  logic [CNT_W-1:0]  pc2, fc2;
  logic              nf;
  logic [BW-1:0]     pass_bcd_a, fail_bcd_a, pass_bcd_b, fail_bcd_b;
  logic              upd_a, busy_a, upd_b, busy_b;
`ifdef MEMTEST_FIRSTFAIL_EN
  logic [BW-1:0]     first_fail_bcd, ffb_a, ffb_b;
  logic              fail_seen, fs_a, fs_b;
`endif

  memtest_stats_bcd u_dut (
    .clk(clk), .rst(rst), .passcount(passcount), .failcount(failcount),
    .force_update(force_update), .pass_bcd(pass_bcd), .fail_bcd(fail_bcd),
    .upd(upd), .busy(busy)
`ifdef MEMTEST_FIRSTFAIL_EN
    , .first_fail_bcd(first_fail_bcd), .fail_seen(fail_seen)
`endif
  );

  memtest_stats_bcd #(.REFRESH_DIV(100)) u_r100 (
    .clk(clk), .rst(rst2), .passcount(pc2), .failcount(fc2),
    .force_update(nf), .pass_bcd(pass_bcd_a), .fail_bcd(fail_bcd_a),
    .upd(upd_a), .busy(busy_a)
`ifdef MEMTEST_FIRSTFAIL_EN
    , .first_fail_bcd(ffb_a), .fail_seen(fs_a)
`endif
  );

  memtest_stats_bcd #(.REFRESH_DIV(50)) u_r50 (
    .clk(clk), .rst(rst2), .passcount(pc2), .failcount(fc2),
    .force_update(nf), .pass_bcd(pass_bcd_b), .fail_bcd(fail_bcd_b),
    .upd(upd_b), .busy(busy_b)
`ifdef MEMTEST_FIRSTFAIL_EN
    , .first_fail_bcd(ffb_b), .fail_seen(fs_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] f;
    logic [BW-1:0]    ep;
    logic [BW-1:0]    ef;
  } vec_t;

  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_upd(input int w);
    case (w)
      1:       return upd_a;
      2:       return upd_b;
      default: return upd;
    endcase
  endfunction

  // Steps until the selected instance pulses upd or the bound expires.
  task automatic wait_upd(input int w, input int bound, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!sel_upd(w) && cyc < bound);
    chk("upd_seen", 64'(sel_upd(w)), 64'd1);
  endtask

  initial begin
    int cyc;
    int extra;
    bit got;

    vecs[0] = '{32'd1234567890, 32'd0,          40'h1234567890, 40'h0};
    vecs[1] = '{32'hFFFFFFFF,   32'd9,          40'h4294967295, 40'h0000000009};
    vecs[2] = '{32'd99999,      32'd100000,     40'h99999,      40'h100000};
    vecs[3] = '{32'd1000000000, 32'd4000000000, 40'h1000000000, 40'h4000000000};
    vecs[4] = '{32'd5,          32'd59,         40'h5,          40'h59};
    vecs[5] = '{32'd0,          32'd0,          40'h0,          40'h0};

    rst = 1'b1; rst2 = 1'b1;
    passcount = '0; failcount = '0; force_update = 1'b0;
    pc2 = 32'd77; fc2 = 32'd0; nf = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_pass_bcd", 64'(pass_bcd), 64'd0);
    chk("rst_fail_bcd", 64'(fail_bcd), 64'd0);
    chk("rst_upd",      64'(upd),      64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    rst = 1'b0; rst2 = 1'b0;

    // No update without a tick or force
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (upd) extra++;
    end
    chk("no_upd_before_tick", 64'(extra), 64'd0);

    // Conversion vectors
    for (int i = 0; i < 6; i++) begin
      passcount    = vecs[i].p;
      failcount    = vecs[i].f;
      force_update = 1'b1;
      step();
      force_update = 1'b0;
      chk($sformatf("v%0d_busy_after_accept", i), 64'(busy), 64'd1);
      wait_upd(0, 200, cyc);
      chk($sformatf("v%0d_latency", i),  64'(cyc),      64'(LAT));
      chk($sformatf("v%0d_pass_bcd", i), 64'(pass_bcd), 64'(vecs[i].ep));
      chk($sformatf("v%0d_fail_bcd", i), 64'(fail_bcd), 64'(vecs[i].ef));
      chk($sformatf("v%0d_busy_at_upd", i), 64'(busy), 64'd0);
      step();
      chk($sformatf("v%0d_upd_one_cycle", i), 64'(upd), 64'd0);
    end

    // Coherency: counts change and forces arrive during a conversion
    passcount = 32'd100; failcount = 32'd200;
    force_update = 1'b1;
    step();
    got = 1'b0; cyc = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      if (c == 10) begin
        passcount = 32'd5;
        failcount = 32'd7;
      end
      force_update = (c == 20 || c == 30);
      step();
      if (upd) begin
        got = 1'b1;
        cyc = c;
      end
    end
    force_update = 1'b0;
    chk("coh_latency1", 64'(cyc),      64'(LAT));
    chk("coh_pass1",    64'(pass_bcd), 64'h100);
    chk("coh_fail1",    64'(fail_bcd), 64'h200);
    step();
    chk("coh_chain_busy", 64'(busy), 64'd1);
    wait_upd(0, 200, cyc);
    chk("coh_latency2", 64'(cyc),      64'(LAT));
    chk("coh_pass2",    64'(pass_bcd), 64'h5);
    chk("coh_fail2",    64'(fail_bcd), 64'h7);
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (upd) extra++;
    end
    chk("coh_no_third_upd", 64'(extra), 64'd0);

    // Reset in the middle of a conversion
    passcount = 32'd11; failcount = 32'd22;
    force_update = 1'b1;
    step();
    force_update = 1'b0;
    repeat (29) step();
    rst = 1'b1;
    #1;
    chk("midrst_pass_bcd", 64'(pass_bcd), 64'd0);
    chk("midrst_fail_bcd", 64'(fail_bcd), 64'd0);
    chk("midrst_busy",     64'(busy),     64'd0);
    chk("midrst_upd",      64'(upd),      64'd0);
    repeat (3) step();
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (upd) extra++;
    end
    chk("midrst_no_upd", 64'(extra), 64'd0);

`ifdef MEMTEST_FIRSTFAIL_EN
    // First-fail capture
    passcount = 32'd42; failcount = 32'd0;
    force_update = 1'b1;
    step();
    force_update = 1'b0;
    wait_upd(0, 200, cyc);
    chk("ff_seen_clear", 64'(fail_seen),      64'd0);
    chk("ff_bcd_clear",  64'(first_fail_bcd), 64'd0);
    failcount = 32'd3;
    force_update = 1'b1;
    step();
    force_update = 1'b0;
    wait_upd(0, 200, cyc);
    chk("ff_latency",   64'(cyc),            64'd97);
    chk("ff_seen",      64'(fail_seen),      64'd1);
    chk("ff_bcd",       64'(first_fail_bcd), 64'h42);
    chk("ff_fail_bcd",  64'(fail_bcd),       64'h3);
    passcount = 32'd99; failcount = 32'd4;
    force_update = 1'b1;
    step();
    force_update = 1'b0;
    wait_upd(0, 200, cyc);
    chk("ff_bcd_sticky", 64'(first_fail_bcd), 64'h42);
    chk("ff_pass_new",   64'(pass_bcd),       64'h99);
`endif

    // Automatic refresh cadence
    wait_upd(1, 300, cyc);
    wait_upd(1, 300, cyc);
    chk("r100_interval1", 64'(cyc), 64'd100);
    wait_upd(1, 300, cyc);
    chk("r100_interval2", 64'(cyc), 64'd100);
    chk("r100_pass_bcd",  64'(pass_bcd_a), 64'h77);
    wait_upd(2, 300, cyc);
    wait_upd(2, 300, cyc);
    chk("r50_interval1", 64'(cyc), 64'(CAD50));
    wait_upd(2, 300, cyc);
    chk("r50_interval2", 64'(cyc), 64'(CAD50));
    chk("r50_fail_bcd",  64'(fail_bcd_b), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
